// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface div_sequencer_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller: restoring division over one shared external
// 32-bit subtractor, used for operand negation, the 32 iterations and sign fixup.
module div_sequencer #(
  parameter logic [31:0] DBZ_QUO      = 32'hFFFF_FFFF,
  parameter bit          DBZ_REM_PASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  div_sequencer_if.slave   div,
  output logic [31:0]      sub_a,
  output logic [31:0]      sub_b,
  input  logic [31:0]      sub_diff,
  input  logic             sub_borrow
);

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    ITER,
    FIX_Q,
    FIX_R,
    DONE
  } state_t;

  state_t      state, state_nx;

  logic        sgn;
  logic [31:0] a_raw;
  logic [31:0] b_raw;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] b_mag;
  logic [31:0] q;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic        dbz;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [32:0] shifted;
  logic        take;

  assign div.busy        = (state != IDLE);
  assign div.done        = (state == DONE);
  assign div.div_by_zero = dbz;
  assign div.quotient    = quo_r;
  assign div.remainder   = rem_r;

  // Partial remainder can exceed 32 bits for one cycle, so the carry-out bit
  // forces a subtract even when the 32-bit subtractor reports a borrow.
  assign shifted = {rem, q[31]};
  assign take    = shifted[32] | ~sub_borrow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sub_a    = '0;
    sub_b    = '0;
    case (state)
      IDLE: begin
        if (div.start) state_nx = NEG_A;
      end
      NEG_A: begin
        if (neg_r) sub_b = a_raw;
        state_nx = NEG_B;
      end
      NEG_B: begin
        if (sgn && b_raw[31]) sub_b = b_raw;
        state_nx = dbz ? DONE : ITER;
      end
      ITER: begin
        sub_a = shifted[31:0];
        sub_b = b_mag;
        if (cnt == 5'd31) state_nx = FIX_Q;
      end
      FIX_Q: begin
        if (neg_q) sub_b = q;
        state_nx = FIX_R;
      end
      FIX_R: begin
        if (neg_r) sub_b = rem;
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sgn   <= 1'b0;
      a_raw <= '0;
      b_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      b_mag <= '0;
      q     <= '0;
      rem   <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
      quo_r <= '0;
      rem_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div.start) begin
            sgn   <= div.is_signed;
            a_raw <= div.dividend;
            b_raw <= div.divisor;
            neg_q <= div.is_signed & (div.dividend[31] ^ div.divisor[31]);
            neg_r <= div.is_signed & div.dividend[31];
            dbz   <= (div.divisor == '0);
          end
        end
        NEG_A: begin
          q <= neg_r ? sub_diff : a_raw;
        end
        NEG_B: begin
          if (dbz) begin
            quo_r <= DBZ_QUO;
            rem_r <= DBZ_REM_PASS ? a_raw : '0;
          end else begin
            b_mag <= (sgn && b_raw[31]) ? sub_diff : b_raw;
            rem   <= '0;
            cnt   <= '0;
          end
        end
        ITER: begin
          rem <= take ? sub_diff : shifted[31:0];
          q   <= {q[30:0], take};
          cnt <= cnt + 5'd1;
        end
        FIX_Q: begin
          quo_r <= neg_q ? sub_diff : q;
        end
        FIX_R: begin
          rem_r <= neg_r ? sub_diff : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-vector bench for div_sequencer: stimulus pushes expected results into
// a scoreboard queue, a negedge monitor pops and checks on every done pulse.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sub_a, sub_b, sub_diff;
  logic        sub_borrow;

  div_sequencer_if dif();

  div_sequencer #(
    .DBZ_QUO      (32'hFFFF_FFFF),
    .DBZ_REM_PASS (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div        (dif),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_diff   (sub_diff),
    .sub_borrow (sub_borrow)
  );

  always #5 clk = ~clk;

  assign sub_diff   = sub_a - sub_b;
  assign sub_borrow = (sub_a < sub_b);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string tag, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dif.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(dif.done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_quo"}, dif.quotient, e.q);
          chk({e.tag, "_rem"}, dif.remainder, e.r);
          chk({e.tag, "_dbz"}, 32'(dif.div_by_zero), 32'(e.dbz));
          chk({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
        end
      end
      if (!dif.busy) begin
        chk("idle_sub_a", sub_a, 32'd0);
        chk("idle_sub_b", sub_b, 32'd0);
      end
    end
  end

  // Done is expected 36 edges after the accepting edge (2 on divide-by-zero).
  task automatic issue(string tag, bit sgn, logic [31:0] a, logic [31:0] b,
                       logic [31:0] eq, logic [31:0] er, bit edbz);
    exp_t e;
    @(negedge clk);
    dif.start     = 1'b1;
    dif.is_signed = sgn;
    dif.dividend  = a;
    dif.divisor   = b;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.due = cyc + 1 + (edbz ? 2 : 36);
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
    chk({tag, "_busy"}, 32'(dif.busy), 32'd1);
  endtask

  task automatic wait_idle(string tag);
    int k = 0;
    while ((dif.busy || sb.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    chk({tag, "_idle"}, 32'(dif.busy), 32'd0);
  endtask

  task automatic run(string tag, bit sgn, logic [31:0] a, logic [31:0] b,
                     logic [31:0] eq, logic [31:0] er, bit edbz);
    issue(tag, sgn, a, b, eq, er, edbz);
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_dbz",  32'(dif.div_by_zero), 32'd0);
    chk("rst_quo",  dif.quotient, 32'd0);
    chk("rst_rem",  dif.remainder, 32'd0);
    chk("rst_sub_a", sub_a, 32'd0);
    chk("rst_sub_b", sub_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run("divu_m7_2",    1'b0, 32'hFFFF_FFF9,  32'h2,          32'h7FFF_FFFC,  32'd1,          1'b0);
    run("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
    run("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    run("divu_dbz",     1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1);
    run("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
    run("div_m7_m2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0);
    run("divu_big",     1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0);
    run("divu_0_5",     1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0);

    // A second start raised mid-iteration must be ignored entirely.
    issue("hold", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 32'd5;
    dif.divisor  = 32'd0;
    repeat (3) @(negedge clk);
    dif.start = 1'b0;
    wait_idle("hold");
    run("after_hold",   1'b0, 32'd77,         32'd7,          32'd11,         32'd0,          1'b0);

    // Leave nonzero held results and a set flag, then abort an operation.
    run("div_dbz_neg",  1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
    @(negedge clk);
    dif.start     = 1'b1;
    dif.is_signed = 1'b0;
    dif.dividend  = 32'h0000_FFFF;
    dif.divisor   = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_done", 32'(dif.done), 32'd0);
    chk("abort_quo",  dif.quotient, 32'd0);
    chk("abort_rem",  dif.remainder, 32'd0);
    chk("abort_dbz",  32'(dif.div_by_zero), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run("after_rst_9_3", 1'b0, 32'd9,         32'd3,          32'd3,          32'd0,          1'b0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
